mips_control_decoder: RTL and testbench
=======================================

// Module: mips_control_decoder
// PURPOSE
//  Single-cycle MIPS control unit: decodes opcode/func into datapath steering signals, ALU op and write enables.
//  Resolves branch-taken from ALU flags. Owns the sticky halted register; SYSCALL stops the core.
//  Sits beside the datapath in the core top; all outputs except halted are combinational.
// PARAMETERS
//  OP_W    6  opcode field width (inst[31:26])
//  FUNC_W  6  function field width (inst[5:0])
//  ALUOP_W 4  ALU operation code width
// PORTS
//  clk                    in   1  rising-edge clock
//  rst_b                  in   1  reset, synchronous, active-high (despite name)
//  opcode                 in   6  inst[31:26]
//  func                   in   6  inst[5:0], used only when opcode==0
//  zero                   in   1  ALU result == 0 (ALU computes rs-rt for branches)
//  negative               in   1  ALU result sign bit
//  alu_src                out  1  1=ALU B uses extended immediate, 0=rt
//  reg_dest               out  1  1=write rd, 0=write rt (jal forces r31 in datapath)
//  pc_or_mem              out  1  1=write-back PC+4 (jal/jalr link)
//  mem_or_reg             out  1  1=write-back memory data (lw), 0=ALU result
//  branch                 out  1  conditional branch TAKEN this cycle
//  jump                   out  1  j/jal: PC <= {PC+4[31:28], target, 2'b00}
//  jump_register          out  1  jr/jalr: PC <= rs
//  reg_write_enable       out  1  register file write
//  does_shift_amount_need out  1  ALU A = shamt (sll/srl/sra)
//  alu_operation          out  4  alu_op_e code
//  mem_write_en           out  1  data memory write (sw)
//  is_unsigned            out  1  unsigned compare for SLT; zero-extend imm for andi/ori/xori
//  halted                 out  1  registered, sticky halt flag
// BEHAVIOUR
//  - Reset (rst_b=1 at edge): halted<=0. Other outputs are pure decode, no reset state.
//  - halted<=1 at edge when opcode==0 && func==6'h0C (SYSCALL); stays 1 until reset. Reset wins if coincident.
//  - While halted==1: reg_write_enable, mem_write_en, branch, jump, jump_register forced 0.
//  - R-type (op 0): reg_dest=1, reg_write_enable=1, alu_src=0. func: 20 add,21 addu->ADD; 22 sub,23 subu->SUB;
//    24 AND;25 OR;26 XOR;27 NOR;2A SLT;2B SLT+is_unsigned; 00 SLL,02 SRL,03 SRA with does_shift_amount_need=1;
//    08 jr: jump_register=1, no write; 09 jalr: jump_register=1, pc_or_mem=1, write rd.
//  - I-type (alu_src=1, write rt): 08 addi,09 addiu ADD; 0A slti SLT; 0B sltiu SLT+unsigned; 0C andi,0D ori,
//    0E xori with is_unsigned=1; 0F lui LUI. 23 lw: ADD, mem_or_reg=1. 2B sw: ADD, mem_write_en=1, no reg write.
//  - Branch (alu_src=0, ALU SUB, no writes): 04 beq taken=zero; 05 bne ~zero; 06 blez zero|negative; 07 bgtz ~zero&~negative.
//  - 02 j: jump=1. 03 jal: jump=1, pc_or_mem=1, reg_write_enable=1.
//  - Unlisted opcode/func: all enables 0, alu_operation=ADD (NOP). Defaults for every output are 0.
//  - alu_op_e: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 SLL=7 SRL=8 SRA=9 LUI=10; 11-15 reserved.
// CONFIGURATION
//  - ILLEGAL_INST_HALT_EN defined: unlisted opcode/func sets halted at next edge (like SYSCALL).
//  - Not defined: unlisted encodings are NOPs; only SYSCALL halts.
// STRUCTURE
//  - Package mips_cu_pkg: alu_op_e enum, OP_* and FN_* localparams, OP_W/FUNC_W/ALUOP_W.
//  - Sub-module mips_alu_func_decoder: func -> alu_operation/is_unsigned/does_shift_amount_need for R-type.
//  - Top: opcode case, branch resolution, halted flop, halt gating.
// TESTING
//  - Reset: rst_b=1 one edge -> halted=0; op 0x23 -> mem_or_reg=1, alu_src=1, reg_write_enable=1, ALU ADD.
//  - R-type sweep: op0 func 0x22 -> alu_operation=1, reg_dest=1; func 0x03 -> 9, does_shift_amount_need=1.
//  - Branches: beq zero=1 -> branch=1; bne zero=1 -> 0; blez neg=1 -> 1; bgtz zero=0 neg=0 -> 1.
//  - Jumps: jal -> jump=1, pc_or_mem=1, reg_write_enable=1; jalr -> jump_register=1, reg_dest=1.
//  - Halt: SYSCALL edge -> halted=1; then sw -> mem_write_en=0; stays 1 until rst_b=1 edge.
//  - Illegal op 0x3F: NOP, halted=0 without macro; halted=1 next edge with ILLEGAL_INST_HALT_EN.

Source files
------------

// File: rtl/mips_cu_pkg.sv
// Shared encodings for the MIPS control decoder: field widths, opcode/func values, ALU op codes.
package mips_cu_pkg;

  localparam int OP_W    = 6;
  localparam int FUNC_W  = 6;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNC_W-1:0] FN_SLL     = 6'h00;
  localparam logic [FUNC_W-1:0] FN_SRL     = 6'h02;
  localparam logic [FUNC_W-1:0] FN_SRA     = 6'h03;
  localparam logic [FUNC_W-1:0] FN_JR      = 6'h08;
  localparam logic [FUNC_W-1:0] FN_JALR    = 6'h09;
  localparam logic [FUNC_W-1:0] FN_SYSCALL = 6'h0C;
  localparam logic [FUNC_W-1:0] FN_ADD     = 6'h20;
  localparam logic [FUNC_W-1:0] FN_ADDU    = 6'h21;
  localparam logic [FUNC_W-1:0] FN_SUB     = 6'h22;
  localparam logic [FUNC_W-1:0] FN_SUBU    = 6'h23;
  localparam logic [FUNC_W-1:0] FN_AND     = 6'h24;
  localparam logic [FUNC_W-1:0] FN_OR      = 6'h25;
  localparam logic [FUNC_W-1:0] FN_XOR     = 6'h26;
  localparam logic [FUNC_W-1:0] FN_NOR     = 6'h27;
  localparam logic [FUNC_W-1:0] FN_SLT     = 6'h2A;
  localparam logic [FUNC_W-1:0] FN_SLTU    = 6'h2B;

endpackage

// File: rtl/mips_alu_func_decoder.sv
// R-type func field to ALU controls; alu_valid flags funcs that are plain ALU register writes.
module mips_alu_func_decoder
  import mips_cu_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  output alu_op_e           alu_operation,
  output logic              is_unsigned,
  output logic              does_shift_amount_need,
  output logic              alu_valid
);

  always_comb begin
    alu_operation          = ALU_ADD;
    is_unsigned            = 1'b0;
    does_shift_amount_need = 1'b0;
    alu_valid              = 1'b1;
    case (func)
      FN_ADD, FN_ADDU: alu_operation = ALU_ADD;
      FN_SUB, FN_SUBU: alu_operation = ALU_SUB;
      FN_AND:          alu_operation = ALU_AND;
      FN_OR:           alu_operation = ALU_OR;
      FN_XOR:          alu_operation = ALU_XOR;
      FN_NOR:          alu_operation = ALU_NOR;
      FN_SLT:          alu_operation = ALU_SLT;
      FN_SLTU: begin
        alu_operation = ALU_SLT;
        is_unsigned   = 1'b1;
      end
      FN_SLL: begin
        alu_operation          = ALU_SLL;
        does_shift_amount_need = 1'b1;
      end
      FN_SRL: begin
        alu_operation          = ALU_SRL;
        does_shift_amount_need = 1'b1;
      end
      FN_SRA: begin
        alu_operation          = ALU_SRA;
        does_shift_amount_need = 1'b1;
      end
      default: alu_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control_decoder.sv
// Single-cycle MIPS control unit with branch resolution and a sticky halted flag.
// Define ILLEGAL_INST_HALT_EN to make unlisted opcode/func encodings halt the core.
module mips_control_decoder
  import mips_cu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  input  logic              negative,
  output logic              alu_src,
  output logic              reg_dest,
  output logic              pc_or_mem,
  output logic              mem_or_reg,
  output logic              branch,
  output logic              jump,
  output logic              jump_register,
  output logic              reg_write_enable,
  output logic              does_shift_amount_need,
  output alu_op_e           alu_operation,
  output logic              mem_write_en,
  output logic              is_unsigned,
  output logic              halted
);

  alu_op_e fn_alu_operation;
  logic    fn_is_unsigned;
  logic    fn_shift;
  logic    fn_alu_valid;
  logic    halt_req;

  mips_alu_func_decoder u_func_dec (
    .func                   (func),
    .alu_operation          (fn_alu_operation),
    .is_unsigned            (fn_is_unsigned),
    .does_shift_amount_need (fn_shift),
    .alu_valid              (fn_alu_valid)
  );

  always_comb begin
    alu_src                = 1'b0;
    reg_dest               = 1'b0;
    pc_or_mem              = 1'b0;
    mem_or_reg             = 1'b0;
    branch                 = 1'b0;
    jump                   = 1'b0;
    jump_register          = 1'b0;
    reg_write_enable       = 1'b0;
    does_shift_amount_need = 1'b0;
    alu_operation          = ALU_ADD;
    mem_write_en           = 1'b0;
    is_unsigned            = 1'b0;
    halt_req               = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        if (fn_alu_valid) begin
          reg_dest               = 1'b1;
          reg_write_enable       = 1'b1;
          alu_operation          = fn_alu_operation;
          is_unsigned            = fn_is_unsigned;
          does_shift_amount_need = fn_shift;
        end else begin
          case (func)
            FN_JR: begin
              reg_dest      = 1'b1;
              jump_register = 1'b1;
            end
            FN_JALR: begin
              reg_dest         = 1'b1;
              jump_register    = 1'b1;
              pc_or_mem        = 1'b1;
              reg_write_enable = 1'b1;
            end
            FN_SYSCALL: halt_req = 1'b1;
            default: begin
`ifdef ILLEGAL_INST_HALT_EN
              halt_req = 1'b1;
`else
              halt_req = 1'b0;
`endif
            end
          endcase
        end
      end
      OP_ADDI, OP_ADDIU: begin
        alu_src          = 1'b1;
        reg_write_enable = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        alu_src          = 1'b1;
        reg_write_enable = 1'b1;
        alu_operation    = ALU_SLT;
        is_unsigned      = (opcode == OP_SLTIU);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        alu_src          = 1'b1;
        reg_write_enable = 1'b1;
        is_unsigned      = 1'b1;
        alu_operation    = (opcode == OP_ANDI) ? ALU_AND :
                           (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        alu_src          = 1'b1;
        reg_write_enable = 1'b1;
        alu_operation    = ALU_LUI;
      end
      OP_LW: begin
        alu_src          = 1'b1;
        reg_write_enable = 1'b1;
        mem_or_reg       = 1'b1;
      end
      OP_SW: begin
        alu_src      = 1'b1;
        mem_write_en = 1'b1;
      end
      // ALU computes rs-rt, so zero/negative describe the comparison
      OP_BEQ: begin
        alu_operation = ALU_SUB;
        branch        = zero;
      end
      OP_BNE: begin
        alu_operation = ALU_SUB;
        branch        = ~zero;
      end
      OP_BLEZ: begin
        alu_operation = ALU_SUB;
        branch        = zero | negative;
      end
      OP_BGTZ: begin
        alu_operation = ALU_SUB;
        branch        = ~zero & ~negative;
      end
      OP_J: jump = 1'b1;
      OP_JAL: begin
        jump             = 1'b1;
        pc_or_mem        = 1'b1;
        reg_write_enable = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_INST_HALT_EN
        halt_req = 1'b1;
`else
        halt_req = 1'b0;
`endif
      end
    endcase

    // A halted core must not change architectural state or redirect the PC
    if (halted) begin
      reg_write_enable = 1'b0;
      mem_write_en     = 1'b0;
      branch           = 1'b0;
      jump             = 1'b0;
      jump_register    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b)
      halted <= 1'b0;
    else if (halt_req)
      halted <= 1'b1;
  end

endmodule

// File: tb/tb_mips_control_decoder.sv
// Randomized self-checking bench for mips_control_decoder against a rule-level reference model.
module tb_mips_control_decoder;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [5:0] opcode, func;
  logic       zero, negative;
  logic       alu_src, reg_dest, pc_or_mem, mem_or_reg, branch, jump, jump_register;
  logic       reg_write_enable, does_shift_amount_need, mem_write_en, is_unsigned, halted;
  logic [3:0] alu_operation;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic mh;   // model halted flag

`ifdef ILLEGAL_INST_HALT_EN
  localparam bit ILL_HALT = 1'b1;
`else
  localparam bit ILL_HALT = 1'b0;
`endif

  mips_control_decoder dut (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func), .zero(zero), .negative(negative),
    .alu_src(alu_src), .reg_dest(reg_dest), .pc_or_mem(pc_or_mem), .mem_or_reg(mem_or_reg),
    .branch(branch), .jump(jump), .jump_register(jump_register),
    .reg_write_enable(reg_write_enable), .does_shift_amount_need(does_shift_amount_need),
    .alu_operation(alu_operation), .mem_write_en(mem_write_en), .is_unsigned(is_unsigned),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Legal encodings used to bias random stimulus
  int legal_ops[17] = '{'h00,'h02,'h03,'h04,'h05,'h06,'h07,'h08,'h09,'h0A,'h0B,'h0C,'h0D,'h0E,'h0F,'h23,'h2B};
  int legal_fns[19] = '{'h00,'h02,'h03,'h08,'h09,'h0C,'h20,'h21,'h22,'h23,'h24,'h25,'h26,'h27,'h2A,'h2B,'h0C,'h20,'h2A};

  function automatic bit is_legal(input int op, input int fn);
    bit r_ok, i_ok;
    r_ok = (fn == 0) || (fn == 2) || (fn == 3) || (fn == 8) || (fn == 9) || (fn == 'h0C) ||
           (fn >= 'h20 && fn <= 'h27) || (fn == 'h2A) || (fn == 'h2B);
    i_ok = (op >= 2 && op <= 'h0F) || (op == 'h23) || (op == 'h2B);
    return (op == 0) ? r_ok : i_ok;
  endfunction

  function automatic bit model_halt_req(input int op, input int fn);
    if (op == 0 && fn == 'h0C) return 1'b1;
    return ILL_HALT && !is_legal(op, fn);
  endfunction

  // Packed as {alu_src,reg_dest,pc_or_mem,mem_or_reg,branch,jump,jump_register,rwe,shamt,alu[3:0],mwe,uns}
  function automatic logic [14:0] model_dec(input int op, input int fn, input bit z, input bit n, input bit h);
    bit asrc = 0, rd = 0, pcm = 0, mr = 0, br = 0, jp = 0, jr = 0, we = 0, sh = 0, mw = 0, un = 0;
    int alu = 0;
    if (is_legal(op, fn)) begin
      if (op == 0) begin
        rd = (fn != 'h0C);
        we = !(fn == 'h08 || fn == 'h0C);
        jr = (fn == 'h08 || fn == 'h09);
        pcm = (fn == 'h09);
        if (fn >= 'h20 && fn <= 'h23) alu = (fn - 'h20) / 2;
        else if (fn >= 'h24 && fn <= 'h27) alu = 2 + (fn - 'h24);
        else if (fn == 'h2A || fn == 'h2B) begin alu = 6; un = (fn == 'h2B); end
        else if (fn <= 3) begin alu = (fn == 0) ? 7 : 6 + fn; sh = 1; end
      end else if (op >= 4 && op <= 7) begin
        alu = 1;
        br = (op == 4) ? z : (op == 5) ? !z : (op == 6) ? (z || n) : (!z && !n);
      end else if (op == 2 || op == 3) begin
        jp = 1; pcm = (op == 3); we = (op == 3);
      end else begin
        asrc = 1;
        we = (op != 'h2B);
        mw = (op == 'h2B);
        mr = (op == 'h23);
        case (op)
          'h0A: alu = 6;
          'h0B: begin alu = 6; un = 1; end
          'h0C: begin alu = 2; un = 1; end
          'h0D: begin alu = 3; un = 1; end
          'h0E: begin alu = 4; un = 1; end
          'h0F: alu = 10;
          default: alu = 0;
        endcase
      end
    end
    if (h) begin we = 0; mw = 0; br = 0; jp = 0; jr = 0; end
    return {asrc, rd, pcm, mr, br, jp, jr, we, sh, alu[3:0], mw, un};
  endfunction

  always @(posedge clk) begin
    if (rst_b) mh = 1'b0;
    else if (model_halt_req(int'(opcode), int'(func))) mh = 1'b1;
  end

  always @(negedge clk) begin
    logic [14:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = model_dec(int'(opcode), int'(func), zero, negative, mh);
      act_v = {alu_src, reg_dest, pc_or_mem, mem_or_reg, branch, jump, jump_register,
               reg_write_enable, does_shift_amount_need, alu_operation, mem_write_en, is_unsigned};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL decode op=%h fn=%h z=%b n=%b h=%b: got %b expected %b",
                 opcode, func, zero, negative, mh, act_v, exp_v);
      end
      checks++;
      if (halted !== mh) begin
        errors++;
        $display("FAIL halted op=%h fn=%h: got %b expected %b", opcode, func, halted, mh);
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit n, input bit r);
    @(posedge clk);
    #1;
    opcode = op; func = fn; zero = z; negative = n; rst_b = r;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  initial begin
    opcode = 6'h23; func = 6'h00; zero = 1'b0; negative = 1'b0; rst_b = 1'b1;
    drive(6'h23, 6'h00, 0, 0, 1);
    drive(6'h23, 6'h00, 0, 0, 0);
    @(negedge clk); #1;
    lit("reset_halted", 32'(halted), 0);
    lit("lw_mem_or_reg", 32'(mem_or_reg), 1);
    lit("lw_alu_src", 32'(alu_src), 1);
    lit("lw_rwe", 32'(reg_write_enable), 1);
    lit("lw_alu_add", 32'(alu_operation), 0);
    chk_en = 1'b1;

    drive(6'h00, 6'h22, 0, 0, 0); @(negedge clk); #1;
    lit("sub_alu", 32'(alu_operation), 1);
    lit("sub_reg_dest", 32'(reg_dest), 1);
    drive(6'h00, 6'h03, 0, 0, 0); @(negedge clk); #1;
    lit("sra_alu", 32'(alu_operation), 9);
    lit("sra_shamt", 32'(does_shift_amount_need), 1);
    drive(6'h04, 6'h00, 1, 0, 0); @(negedge clk); #1;
    lit("beq_taken", 32'(branch), 1);
    drive(6'h05, 6'h00, 1, 0, 0); @(negedge clk); #1;
    lit("bne_not_taken", 32'(branch), 0);
    drive(6'h06, 6'h00, 0, 1, 0); @(negedge clk); #1;
    lit("blez_taken", 32'(branch), 1);
    drive(6'h07, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("bgtz_taken", 32'(branch), 1);
    drive(6'h03, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("jal_jump", 32'(jump), 1);
    lit("jal_pc_or_mem", 32'(pc_or_mem), 1);
    lit("jal_rwe", 32'(reg_write_enable), 1);
    drive(6'h00, 6'h09, 0, 0, 0); @(negedge clk); #1;
    lit("jalr_jr", 32'(jump_register), 1);
    lit("jalr_reg_dest", 32'(reg_dest), 1);

    drive(6'h3F, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("illegal_rwe", 32'(reg_write_enable), 0);
    lit("illegal_alu", 32'(alu_operation), 0);
    lit("illegal_halted_before", 32'(halted), 0);
    drive(6'h23, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("illegal_halted_after", 32'(halted), 32'(ILL_HALT));
    drive(6'h23, 6'h00, 0, 0, 1);

    drive(6'h00, 6'h0C, 0, 0, 0); @(negedge clk); #1;
    lit("syscall_halted_same_cycle", 32'(halted), 0);
    drive(6'h2B, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("syscall_halted", 32'(halted), 1);
    lit("halted_sw_blocked", 32'(mem_write_en), 0);
    drive(6'h02, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("halted_jump_blocked", 32'(jump), 0);
    lit("halted_sticky", 32'(halted), 1);
    drive(6'h00, 6'h0C, 0, 0, 1);
    drive(6'h2B, 6'h00, 0, 0, 0); @(negedge clk); #1;
    lit("reset_wins_over_syscall", 32'(halted), 0);
    lit("sw_mem_write", 32'(mem_write_en), 1);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) < 7) ? 6'(legal_ops[$urandom_range(0, 16)]) : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 9) < 8) ? 6'(legal_fns[$urandom_range(0, 18)]) : 6'($urandom_range(0, 63));
      drive(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 14) == 0));
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
